// File: rtl/dac_pkg.sv
// Package: dac_pkg
// Purpose: Shared constants, the pacer state encoding and a saturating
//          increment helper for the DAC sample pacer and its FIFO.
// Contents:
//   DAC_WORD_W    - native DAC word width
//   RAMP_STEP     - increment applied to the built-in ramp per popped sample
//   SAT16         - saturation ceiling for the 16-bit event counters
//   pacer_state_t - IDLE / PRIME / RUN
//   sat_inc16()   - add one unless already at SAT16
package dac_pkg;

  localparam int          DAC_WORD_W = 16;
  localparam logic [15:0] RAMP_STEP  = 16'h1000;
  localparam logic [15:0] SAT16      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pacer_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    sat_inc16 = (value == SAT16) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Module: dac_sample_fifo
// Purpose: Synchronous FIFO with flush. Push is ignored when full, pop is
//          ignored when empty, and flush wins over both in the same cycle.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   flush       - clear pointers and level
//   push        - write push_data (ignored when full)
//   push_data   - sample to write
//   pop         - advance read pointer (ignored when empty)
//   head        - sample at the read pointer
//   full, empty - occupancy flags
//   level       - occupancy 0..DEPTH
module dac_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  // full is registered, so a pop in this cycle cannot make room for a push
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Module: dac_sample_pacer
// Purpose: Buffers producer samples in a FIFO and releases exactly one sample
//          per SAMPLE_PERIOD clocks to the DAC serializer, counting underruns
//          (slot found the FIFO empty) and late slots (previous sample not yet
//          taken).
// Configuration macro: RAMP_TEST_EN - when defined, the FIFO input is replaced
//          by an internal ramp (0, +0x1000 per popped sample); s_ready is 0,
//          the source never reads empty and priming completes at once.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   enable         - run the pacer
//   flush          - 1-cycle pulse: empty FIFO, clear sticky flag and counters
//   s_data/s_valid/s_ready - producer side
//   m_data/m_valid/m_ready - DAC driver side
//   fifo_level     - FIFO occupancy
//   underrun       - sticky underrun flag
//   underrun_cnt   - saturating underrun slot count
//   late_cnt       - saturating late slot count
//   state          - current pacer state (observation)
//
// Handshake (both sides): a beat transfers on a clock edge where valid and
// ready are both high. m_valid, once raised, stays high with m_data frozen
// until that transfer; it drops the cycle after. s_ready is simply !full.
module dac_sample_pacer
  import dac_pkg::*;
#(
  parameter int DATA_W        = DAC_WORD_W,
  parameter int DEPTH         = 16,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int PRIME_LEVEL   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       underrun,
  output logic [15:0]                underrun_cnt,
  output logic [15:0]                late_cnt,
  output pacer_state_t               state
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);

  logic [TMR_W-1:0]  timer;
  logic              tick;
  logic              stall;
  logic              src_empty;
  logic [DATA_W-1:0] src_head;
  logic              prime_ok;
  logic              do_pop;
  logic              do_under;
  logic              do_late;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_lvl;

  // A slot only fires while running and still enabled; dropping enable on
  // the tick cycle returns to IDLE without consuming a sample.
  assign tick     = (state == RUN) && enable && (timer == TMR_W'(SAMPLE_PERIOD - 1));
  assign stall    = m_valid && !m_ready;
  assign do_late  = tick && stall;
  assign do_pop   = tick && !stall && !src_empty;
  assign do_under = tick && !stall && src_empty;

  dac_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_lvl)
  );

  assign fifo_level = fifo_lvl;

`ifdef RAMP_TEST_EN
  logic [DATA_W-1:0] ramp;

  assign fifo_push = 1'b0;
  assign fifo_pop  = 1'b0;
  assign s_ready   = 1'b0;
  assign src_empty = 1'b0;
  assign src_head  = ramp;
  assign prime_ok  = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp <= '0;
    end else if (do_pop) begin
      ramp <= ramp + DATA_W'(RAMP_STEP);
    end
  end
`else
  assign fifo_push = s_valid;
  assign fifo_pop  = do_pop;
  assign s_ready   = !fifo_full;
  assign src_empty = fifo_empty;
  assign src_head  = fifo_head;
  assign prime_ok  = (fifo_lvl >= LVL_W'(PRIME_LEVEL));
`endif

  // Pacer FSM and slot timer. Timer is held at zero outside RUN so the
  // first slot lands SAMPLE_PERIOD clocks after entering RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (enable) state <= PRIME;
        end
        PRIME: begin
          timer <= '0;
          if (!enable)       state <= IDLE;
          else if (prime_ok) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == TMR_W'(SAMPLE_PERIOD - 1)) begin
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // Output register. An accepted beat clears m_valid, but a slot firing in
  // the same cycle re-arms it with the next sample. An underrun re-presents
  // the previous m_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (do_pop) begin
        m_data  <= src_head;
        m_valid <= 1'b1;
      end else if (do_under) begin
        m_valid <= 1'b1;
      end
    end
  end

  // Sticky flag and saturating counters; flush clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      late_cnt     <= '0;
    end else if (flush) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      late_cnt     <= '0;
    end else begin
      if (do_late) begin
        late_cnt <= sat_inc16(late_cnt);
      end
      if (do_under) begin
        underrun     <= 1'b1;
        underrun_cnt <= sat_inc16(underrun_cnt);
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
module tb_dac_sample_pacer;
  import dac_pkg::*;

  localparam int DATA_W        = 16;
  localparam int DEPTH         = 16;
  localparam int SAMPLE_PERIOD = 8;
  localparam int PRIME_LEVEL   = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic                  flush;
  logic [DATA_W-1:0]     s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_W-1:0]     m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                  underrun;
  logic [15:0]           underrun_cnt;
  logic [15:0]           late_cnt;
  pacer_state_t          state;

  dac_sample_pacer #(
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .SAMPLE_PERIOD (SAMPLE_PERIOD),
    .PRIME_LEVEL   (PRIME_LEVEL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .late_cnt     (late_cnt),
    .state        (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [DATA_W-1:0] exp_q[$];
  int beat_cnt = 0;
  int beat_cyc[64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every accepted output beat is compared against the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (beat_cnt < 64) beat_cyc[beat_cnt] = cyc;
      beat_cnt++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL beat_unexpected: observed %h expected no beat", m_data);
      end else begin
        check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    s_data  = d;
    s_valid = 1'b1;
    step(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n;
    n = 0;
    while (beat_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check("wait_beats", 32'(beat_cnt >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int base;
    rst_n   = 1'b0;
    enable  = 1'b0;
    flush   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    step(3);

    // reset values
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("rst_late_cnt", 32'(late_cnt), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    step(2);

`ifdef RAMP_TEST_EN
    // ramp source: 0x0000, 0x1000, ... 0xF000, 0x0000
    check("ramp_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 17; i++) exp_q.push_back(16'(i * 32'h1000));
    enable = 1'b1;
    wait_beats(17, 17 * SAMPLE_PERIOD + 40);
    enable = 1'b0;
    step(2);
    check("ramp_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("ramp_underrun", 32'(underrun), 32'd0);
    check("ramp_queue_drained", 32'(exp_q.size()), 32'd0);
`else
    check("rst_s_ready", 32'(s_ready), 32'd1);

    // 1: prime with four samples, one released per slot
    for (int i = 1; i <= 4; i++) begin
      push_word(16'(i * 32'h0100));
      exp_q.push_back(16'(i * 32'h0100));
    end
    check("s1_level", 32'(fifo_level), 32'd4);
    enable = 1'b1;
    step(1);
    check("s1_state_prime", 32'(state), 32'(PRIME));
    step(1);
    check("s1_state_run", 32'(state), 32'(RUN));
    wait_beats(4, 6 * SAMPLE_PERIOD);
    check("s1_valid_pulse", 32'(m_valid), 32'd0);
    for (int i = 0; i < 3; i++)
      check("s1_slot_interval", 32'(beat_cyc[i+1] - beat_cyc[i]), 32'(SAMPLE_PERIOD));

    // 2: drained FIFO -> two repeat slots of the last sample
    exp_q.push_back(16'h0400);
    exp_q.push_back(16'h0400);
    wait_beats(5, 2 * SAMPLE_PERIOD);
    check("s2_underrun", 32'(underrun), 32'd1);
    check("s2_underrun_cnt1", 32'(underrun_cnt), 32'd1);
    wait_beats(6, 2 * SAMPLE_PERIOD);
    check("s2_underrun_cnt2", 32'(underrun_cnt), 32'd2);

    // 3: stall m_ready for 20 clocks while a sample is pending
    for (int i = 5; i <= 7; i++) begin
      push_word(16'(i * 32'h0100));
      exp_q.push_back(16'(i * 32'h0100));
    end
    step(1);
    m_ready = 1'b0;
    step(3);
    check("s3_valid_held", 32'(m_valid), 32'd1);
    check("s3_data_first", 32'(m_data), 32'h0500);
    check("s3_level_first", 32'(fifo_level), 32'd2);
    step(17);
    check("s3_data_stable", 32'(m_data), 32'h0500);
    check("s3_level_no_pop", 32'(fifo_level), 32'd2);
    check("s3_late_cnt", 32'(late_cnt), 32'd2);
    m_ready = 1'b1;
    wait_beats(9, 4 * SAMPLE_PERIOD);
    enable = 1'b0;
    step(1);
    check("s3_state_idle", 32'(state), 32'(IDLE));
    check("s3_underrun_cnt", 32'(underrun_cnt), 32'd2);

    // 4: fill to DEPTH without enable, overflow ignored, flush
    for (int i = 0; i < DEPTH; i++) push_word(16'(32'h2000 + i));
    check("s4_level_full", 32'(fifo_level), 32'(DEPTH));
    check("s4_s_ready_full", 32'(s_ready), 32'd0);
    push_word(16'hDEAD);
    check("s4_overflow_ignored", 32'(fifo_level), 32'(DEPTH));
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("s4_flush_level", 32'(fifo_level), 32'd0);
    check("s4_flush_s_ready", 32'(s_ready), 32'd1);
    check("s4_flush_underrun", 32'(underrun), 32'd0);
    check("s4_flush_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("s4_flush_late_cnt", 32'(late_cnt), 32'd0);

    // 5: reset mid-RUN with a pending sample, then re-prime
    for (int i = 0; i < 4; i++) begin
      push_word(16'(32'h0A00 + i * 32'h0100));
      exp_q.push_back(16'(32'h0A00 + i * 32'h0100));
    end
    m_ready = 1'b0;
    enable  = 1'b1;
    n = 0;
    while (!m_valid && n < 4 * SAMPLE_PERIOD) begin
      step(1);
      n++;
    end
    check("s5_pending_valid", 32'(m_valid), 32'd1);
    check("s5_pending_data", 32'(m_data), 32'(exp_q.pop_front()));
    rst_n = 1'b0;
    #1;
    check("s5_rst_m_valid", 32'(m_valid), 32'd0);
    check("s5_rst_level", 32'(fifo_level), 32'd0);
    check("s5_rst_state", 32'(state), 32'(IDLE));
    exp_q.delete();
    step(2);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    step(2);
    check("s5_prime_wait", 32'(state), 32'(PRIME));
    base = beat_cnt;
    for (int i = 0; i < 3; i++) begin
      push_word(16'(32'h1100 + i * 32'h0100));
      exp_q.push_back(16'(32'h1100 + i * 32'h0100));
    end
    step(1);
    check("s5_prime_below_level", 32'(state), 32'(PRIME));
    push_word(16'h1400);
    exp_q.push_back(16'h1400);
    step(1);
    check("s5_reprime_run", 32'(state), 32'(RUN));
    wait_beats(base + 4, 6 * SAMPLE_PERIOD);
    enable = 1'b0;
    step(2);
    check("s5_underrun_cnt", 32'(underrun_cnt), 32'd0);
    check("s5_queue_drained", 32'(exp_q.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
